// File: rtl/fib_led_sequencer_if.sv
// Control and display bundle of the LED pattern sequencer.
// The block owns the slave side; whoever picks the pattern owns the master side.
interface fib_led_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] leds;
  logic [5:0]       index;
  logic             step;
  logic             wrap;

  modport master (
    output en, mode,
    input  leds, index, step, wrap
  );

  modport slave (
    input  en, mode,
    output leds, index, step, wrap
  );
endinterface

// File: rtl/fib_led_sequencer.sv
// LED pattern sequencer: Fibonacci, binary count, walking one and hold,
// paced by an internal prescaler, with registered step/wrap strobes.
module fib_led_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fib_led_sequencer_if.slave seq_io
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    MODE_FIB  = 2'd0,
    MODE_BIN  = 2'd1,
    MODE_WALK = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  logic [PW-1:0]    pcnt_q, pcnt_d;
  mode_e            mreg_q, mreg_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic [5:0]       index_q, index_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  mode_e            mode_s;
  logic             tick_s;
  logic [WIDTH:0]   sum_s;

  assign mode_s = mode_e'(seq_io.mode);
  assign tick_s = seq_io.en && (pcnt_q == PW'(DIV - 1));
  // The carry bit of a+b marks the last value that still fits the display.
  assign sum_s  = {1'b0, a_q} + {1'b0, b_q};

  // Next-state: mode restart beats tick; hold mode lets the prescaler run idle.
  always_comb begin
    pcnt_d  = pcnt_q;
    mreg_d  = mreg_q;
    a_d     = a_q;
    b_d     = b_q;
    last_d  = last_q;
    leds_d  = leds_q;
    index_d = index_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;

    if (mode_s != mreg_q) begin
      mreg_d  = mode_s;
      pcnt_d  = '0;
      index_d = 6'd0;
      a_d     = '0;
      b_d     = WIDTH'(1);
      last_d  = 1'b0;
      case (mode_s)
        MODE_FIB:  leds_d = '0;
        MODE_BIN:  leds_d = '0;
        MODE_WALK: leds_d = WIDTH'(1);
        MODE_HOLD: leds_d = leds_q;
        default:   leds_d = leds_q;
      endcase
    end else begin
      if (seq_io.en) begin
        pcnt_d = tick_s ? '0 : pcnt_q + PW'(1);
      end else begin
        pcnt_d = pcnt_q;
      end

      if (tick_s) begin
        case (mreg_q)
          MODE_FIB: begin
            step_d = 1'b1;
            if (!last_q) begin
              a_d     = b_q;
              b_d     = sum_s[WIDTH-1:0];
              last_d  = sum_s[WIDTH];
              leds_d  = b_q;
              index_d = index_q + 6'd1;
            end else begin
              a_d     = '0;
              b_d     = WIDTH'(1);
              last_d  = 1'b0;
              leds_d  = '0;
              index_d = 6'd0;
              wrap_d  = 1'b1;
            end
          end
          MODE_BIN: begin
            step_d = 1'b1;
            leds_d = leds_q + WIDTH'(1);
            if (leds_q == '1) begin
              index_d = 6'd0;
              wrap_d  = 1'b1;
            end else begin
              index_d = index_q + 6'd1;
            end
          end
          MODE_WALK: begin
            step_d = 1'b1;
            if (leds_q[WIDTH-1]) begin
              leds_d  = WIDTH'(1);
              index_d = 6'd0;
              wrap_d  = 1'b1;
            end else begin
              leds_d  = leds_q << 1;
              index_d = index_q + 6'd1;
            end
          end
          MODE_HOLD: step_d = 1'b0;
          default:   step_d = 1'b0;
        endcase
      end else begin
        step_d = 1'b0;
      end
    end
  end

  // State registers; reset lands in the Fibonacci start state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q  <= '0;
      mreg_q  <= MODE_FIB;
      a_q     <= '0;
      b_q     <= WIDTH'(1);
      last_q  <= 1'b0;
      leds_q  <= '0;
      index_q <= 6'd0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      mreg_q  <= mreg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      last_q  <= last_d;
      leds_q  <= leds_d;
      index_q <= index_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign seq_io.leds  = leds_q;
  assign seq_io.index = index_q;
  assign seq_io.step  = step_q;
  assign seq_io.wrap  = wrap_q;

endmodule

// File: tb/tb_fib_led_sequencer.sv
// Random-stimulus bench: five sequencer configurations share EN/MODE/RST and
// are compared every cycle against an arithmetic reference model.
module tb_fib_led_sequencer;

  localparam int N = 5;

  function automatic int w_of(input int k);
    case (k)
      0: return 8;
      1: return 2;
      2: return 8;
      3: return 4;
      default: return 16;
    endcase
  endfunction

  function automatic int d_of(input int k);
    case (k)
      0: return 1;
      1: return 1;
      2: return 4;
      3: return 3;
      default: return 2;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;

  logic [31:0] leds_w  [N];
  logic [5:0]  index_w [N];
  logic        step_w  [N];
  logic        wrap_w  [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = w_of(g);
    localparam int D = d_of(g);
    fib_led_sequencer_if #(.WIDTH(W)) bus ();
    assign bus.en   = en;
    assign bus.mode = mode;
    fib_led_sequencer #(.WIDTH(W), .DIV(D)) u_dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .seq_io (bus)
    );
    assign leds_w[g]  = 32'(bus.leds);
    assign index_w[g] = bus.index;
    assign step_w[g]  = bus.step;
    assign wrap_w[g]  = bus.wrap;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state per configuration.
  int              mreg_m [N];
  int              ph_m   [N];
  int              n_m    [N];
  int              p_m    [N];
  longint unsigned leds_m [N];
  int              idx_m  [N];
  bit              step_m [N];
  bit              wrap_m [N];

  function automatic longint unsigned fib(input int n);
    longint unsigned x = 0, y = 1, t;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic model_step(input int k);
    int W = w_of(k);
    int D = d_of(k);
    longint unsigned lim = 64'd1 << W;
    bit tick;
    step_m[k] = 1'b0;
    wrap_m[k] = 1'b0;
    if (rst) begin
      mreg_m[k] = 0; ph_m[k] = 0; n_m[k] = 0; p_m[k] = 0;
      leds_m[k] = 0; idx_m[k] = 0;
    end else if (int'(mode) != mreg_m[k]) begin
      mreg_m[k] = int'(mode); ph_m[k] = 0; n_m[k] = 0; p_m[k] = 0; idx_m[k] = 0;
      if (mode == 2'd0 || mode == 2'd1) leds_m[k] = 0;
      else if (mode == 2'd2) leds_m[k] = 1;
    end else begin
      tick = 1'b0;
      if (en) begin
        ph_m[k]++;
        if (ph_m[k] == D) begin
          tick = 1'b1;
          ph_m[k] = 0;
        end
      end
      if (tick && mreg_m[k] != 3) begin
        step_m[k] = 1'b1;
        case (mreg_m[k])
          0: begin
            if (fib(n_m[k] + 1) < lim) n_m[k]++;
            else begin n_m[k] = 0; wrap_m[k] = 1'b1; end
            leds_m[k] = fib(n_m[k]);
            idx_m[k]  = n_m[k];
          end
          1: begin
            leds_m[k] = (leds_m[k] + 1) % lim;
            if (leds_m[k] == 0) begin wrap_m[k] = 1'b1; idx_m[k] = 0; end
            else idx_m[k] = (idx_m[k] + 1) % 64;
          end
          default: begin
            if (p_m[k] == W - 1) begin p_m[k] = 0; wrap_m[k] = 1'b1; end
            else p_m[k]++;
            leds_m[k] = 64'd1 << p_m[k];
            idx_m[k]  = p_m[k];
          end
        endcase
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < N; k++) model_step(k);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("leds[%0d]", k),  64'(leds_w[k]),  leds_m[k]);
      chk($sformatf("index[%0d]", k), 64'(index_w[k]), 64'(idx_m[k]));
      chk($sformatf("step[%0d]", k),  64'(step_w[k]),  64'(step_m[k]));
      chk($sformatf("wrap[%0d]", k),  64'(wrap_w[k]),  64'(wrap_m[k]));
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0;
    @(negedge clk);
    repeat (2) cycle();
    rst = 1'b0; en = 1'b1;
    repeat (20) cycle();
    mode = 2'd2;
    repeat (12) cycle();
    mode = 2'd0;
    repeat (9) cycle();
    mode = 2'd3;
    repeat (20) cycle();
    mode = 2'd1;
    repeat (6) cycle();
    en = 1'b0;
    repeat (10) cycle();
    en = 1'b1;
    repeat (8) cycle();
    mode = 2'd0;
    repeat (11) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (5) cycle();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
